// File: rtl/uart_tx_frame_gen_if.sv
// Byte-input handshake between a byte source and the UART frame generator.
// Per-frame line options travel with the data so they are latched together.
interface uart_tx_frame_gen_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [1:0]           parity_mode;
  logic                 two_stop;

  modport master (
    output s_data,
    output s_valid,
    output parity_mode,
    output two_stop,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  parity_mode,
    input  two_stop,
    output s_ready
  );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: start, LSB-first data, optional parity, 1/2 stops, then a mark gap.
// Timing comes from a bit-period counter in the system clock domain.
module uart_tx_frame_gen #(
  parameter int unsigned CLKS_PER_BIT  = 1087,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned IDLE_GAP_BITS = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_frame_gen_if.slave  bus,
  output logic                tx_out,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP_BITS - 1);
  localparam bit               HAS_GAP   = (IDLE_GAP_BITS != 0);

  logic [2:0]           state_q,    state_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0]     sub_cnt_q,  sub_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_en_q,   par_en_d;
  logic                 par_bit_q,  par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 ready_q,    ready_d;
  logic                 tx_d, busy_d, frame_done_d;
  logic                 bit_last, accept;

  assign bus.s_ready = ready_q;

  // Next-state and next-output logic; outputs reflect the state one clk later,
  // which places the start bit on the edge after the accepting edge.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    two_stop_d   = two_stop_q;
    tx_d         = 1'b1;
    frame_done_d = 1'b0;
    bit_last     = (bit_cnt_q == BIT_LAST);
    accept       = bus.s_valid && ready_q;

    if (state_q != S_IDLE) begin
      bit_cnt_d = bit_last ? '0 : bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        sub_cnt_d = '0;
        if (accept) begin
          state_d    = S_START;
          shift_d    = bus.s_data;
          par_en_d   = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
          par_bit_d  = (^bus.s_data) ^ (bus.parity_mode == 2'b10);
          two_stop_d = bus.two_stop;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_last) begin
          state_d   = S_DATA;
          sub_cnt_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (sub_cnt_q == DATA_LAST) begin
            sub_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            sub_cnt_d = sub_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        tx_d = par_bit_q;
        if (bit_last) begin
          state_d   = S_STOP;
          sub_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          if (two_stop_q && (sub_cnt_q == '0)) begin
            sub_cnt_d = CNT_W'(1);
          end else begin
            frame_done_d = 1'b1;
            sub_cnt_d    = '0;
            state_d      = HAS_GAP ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (bit_last) begin
          if (sub_cnt_q == GAP_LAST) begin
            sub_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            sub_cnt_d = sub_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        sub_cnt_d = '0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset also aborts a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      sub_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      ready_q    <= 1'b1;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      ready_q    <= ready_d;
      tx_out     <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
